// File: rtl/mips_trace_capture.sv
// Debug trace buffer beside mips_top: records {pc, ula, dmem} per qualified core cycle into a
// circular FIFO, optionally started by a PC-match trigger, drained through a FWFT read port.
module mips_trace_capture #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       ula_in,
  input  logic [31:0]       dmem_in,
  input  logic              sample_en,
  input  logic              arm,
  input  logic              stop,
  input  logic              trig_en,
  input  logic [31:0]       trig_pc,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [31:0]       rd_pc,
  output logic [31:0]       rd_ula,
  output logic [31:0]       rd_dmem,
  output logic [ADDR_W:0]   count,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } state_e;

  localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
  logic              wr_en, rd_en;
  logic [95:0]       mem [DEPTH];

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    wr_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arm && !stop) begin
          state_d  = StArmed;
          wr_cnt_d = '0;
        end
      end
      StArmed: begin
        if (stop) begin
          state_d = StDone;
        end else if (!trig_en) begin
          state_d = StCapture;
        end else if (sample_en && (pc_in == trig_pc)) begin
          // The trigger cycle itself becomes record 0.
          wr_en    = 1'b1;
          wr_cnt_d = CntOne;
          state_d  = StCapture;
        end
      end
      StCapture: begin
        if (stop) begin
          state_d = StDone;
        end else if (sample_en) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + CntOne;
          if (wr_cnt_d == DepthCnt) state_d = StDone;
        end
      end
      StDone: begin
        if (count_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_valid = (count_q != '0);
  assign rd_en    = rd_valid && rd_ready;
  assign count_d  = count_q + (ADDR_W + 1)'(wr_en) - (ADDR_W + 1)'(rd_en);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      count_q  <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Record storage needs no reset; an empty buffer masks the read data to zero.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) mem[wr_ptr_q] <= {pc_in, ula_in, dmem_in};
  end

  always_comb begin
    {rd_pc, rd_ula, rd_dmem} = '0;
    if (rd_valid) {rd_pc, rd_ula, rd_dmem} = mem[rd_ptr_q];
  end

  assign count = count_q;
  assign state = state_q;

endmodule

// File: tb/tb_mips_trace_capture.sv
// Scoreboard bench for mips_trace_capture: expected PCs are queued as samples are driven and
// compared against the read port whenever a record is transferred.
module tb_mips_trace_capture;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_in, ula_in, dmem_in, trig_pc;
  logic        sample_en, arm, stop, trig_en, rd_ready;
  logic        rd_valid;
  logic [31:0] rd_pc, rd_ula, rd_dmem;
  logic [4:0]  count;
  logic [1:0]  state;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  mips_trace_capture #(.DEPTH(16), .ADDR_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .pc_in     (pc_in),
    .ula_in    (ula_in),
    .dmem_in   (dmem_in),
    .sample_en (sample_en),
    .arm       (arm),
    .stop      (stop),
    .trig_en   (trig_en),
    .trig_pc   (trig_pc),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_pc     (rd_pc),
    .rd_ula    (rd_ula),
    .rd_dmem   (rd_dmem),
    .count     (count),
    .state     (state)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ula_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] dmem_of(input logic [31:0] pc);
    return pc + 32'h1000_0003;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_sample(input logic en, input logic [31:0] pc);
    sample_en = en;
    pc_in     = pc;
    ula_in    = ula_of(pc);
    dmem_in   = dmem_of(pc);
  endtask

  task automatic pulse_arm;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] exp, input int budget);
    for (int i = 0; i < budget && state != exp; i++) tick();
    check_eq("wait_state", 32'(state), 32'(exp));
  endtask

  task automatic drain;
    rd_ready = 1'b1;
    for (int i = 0; i < 40 && count != 0; i++) tick();
    rd_ready = 1'b0;
    check_eq("drain_count", 32'(count), 0);
    check_eq("drain_queue", exp_q.size(), 0);
  endtask

  // Scoreboard side: every transfer must match the oldest expected record.
  always @(negedge clock) begin
    if (!reset && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("rd_extra", 32'(count), 0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check_eq("rd_pc", rd_pc, e);
        check_eq("rd_ula", rd_ula, ula_of(e));
        check_eq("rd_dmem", rd_dmem, dmem_of(e));
      end
    end
  end

  initial begin
    int pushed;
    logic [31:0] pc;

    reset = 1'b1; arm = 1'b0; stop = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_ready = 1'b0;
    drive_sample(1'b0, '0);
    tick();
    tick();
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_valid", 32'(rd_valid), 0);
    check_eq("rst_pc", rd_pc, 0);
    reset = 1'b0;

    // Immediate capture of 16 records, then hold without reading.
    pulse_arm();
    check_eq("t1_armed", 32'(state), 1);
    tick();
    check_eq("t1_capture", 32'(state), 2);
    for (int i = 0; i < 16; i++) begin
      drive_sample(1'b1, 32'(4 * i));
      exp_q.push_back(32'(4 * i));
      tick();
    end
    drive_sample(1'b0, '0);
    check_eq("t1_done", 32'(state), 3);
    check_eq("t1_count", 32'(count), 16);
    tick();
    check_eq("t1_hold_pc", rd_pc, 32'h0);

    // Drain all 16; DONE persists one edge after count hits zero.
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    rd_ready = 1'b0;
    check_eq("t2_count", 32'(count), 0);
    check_eq("t2_still_done", 32'(state), 3);
    tick();
    check_eq("t2_idle", 32'(state), 0);

    // PC-match trigger at 0x20.
    trig_en = 1'b1;
    trig_pc = 32'h20;
    pulse_arm();
    check_eq("t3_armed", 32'(state), 1);
    pc = 0;
    pushed = 0;
    for (int i = 0; i < 64 && state != 3; i++) begin
      drive_sample(1'b1, pc);
      if (pc >= 32'h20 && pushed < 16) begin
        exp_q.push_back(pc);
        pushed++;
      end
      pc += 4;
      tick();
    end
    drive_sample(1'b0, '0);
    trig_en = 1'b0;
    check_eq("t3_done", 32'(state), 3);
    check_eq("t3_count", 32'(count), 16);
    check_eq("t3_head", rd_pc, 32'h20);
    drain();
    wait_state(2'd0, 4);

    // Early stop after 5 records; the stop-cycle sample must be dropped.
    pulse_arm();
    tick();
    for (int i = 0; i < 5; i++) begin
      drive_sample(1'b1, 32'h100 + 32'(4 * i));
      exp_q.push_back(32'h100 + 32'(4 * i));
      tick();
    end
    drive_sample(1'b1, 32'h114);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    drive_sample(1'b0, '0);
    check_eq("t4_done", 32'(state), 3);
    check_eq("t4_count", 32'(count), 5);
    drain();
    wait_state(2'd0, 4);

    // Concurrent capture and drain.
    rd_ready = 1'b1;
    pulse_arm();
    tick();
    check_eq("t5_valid_pre", 32'(rd_valid), 0);
    for (int i = 0; i < 16; i++) begin
      drive_sample(1'b1, 32'h200 + 32'(4 * i));
      exp_q.push_back(32'h200 + 32'(4 * i));
      tick();
      if (i == 0) check_eq("t5_valid_first", 32'(rd_valid), 1);
      check_eq("t5_count_le1", 32'(count <= 5'd1), 1);
    end
    drive_sample(1'b0, '0);
    wait_state(2'd0, 8);
    rd_ready = 1'b0;
    check_eq("t5_queue", exp_q.size(), 0);

    // Reset mid-capture with 7 records held.
    pulse_arm();
    tick();
    for (int i = 0; i < 7; i++) begin
      drive_sample(1'b1, 32'h300 + 32'(4 * i));
      exp_q.push_back(32'h300 + 32'(4 * i));
      tick();
    end
    check_eq("t6_pre_count", 32'(count), 7);
    check_eq("t6_pre_state", 32'(state), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_sample(1'b0, '0);
    check_eq("t6_rst_count", 32'(count), 0);
    check_eq("t6_rst_valid", 32'(rd_valid), 0);
    check_eq("t6_rst_state", 32'(state), 0);
    exp_q.delete();

    // arm while DONE still holds records is ignored.
    pulse_arm();
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_sample(1'b1, 32'h400 + 32'(4 * i));
      exp_q.push_back(32'h400 + 32'(4 * i));
      tick();
    end
    drive_sample(1'b0, '0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("t6_done", 32'(state), 3);
    pulse_arm();
    check_eq("t6_arm_ign_state", 32'(state), 3);
    check_eq("t6_arm_ign_count", 32'(count), 3);
    tick();
    check_eq("t6_arm_ign_state2", 32'(state), 3);
    drain();
    wait_state(2'd0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_trace_capture.md
Name: mips_trace_capture

Overview:
- Debug trace buffer on the observation side of mips_top: consumes the per-cycle PC, ULA result and data-memory read value the core exports and records them.
- Records are held in a circular FIFO of DEPTH entries, started by an optional PC-match trigger.
- A host or testbench drains records through a valid/ready read port.
- Sits beside mips_top in the top-level; no effect on core execution.

Parameters:
DEPTH, 16, number of trace records; power of two, minimum 2.
ADDR_W, 4, log2(DEPTH); width of read/write pointers.

Ports:
clock  in  1  single system clock; all logic on rising edge.
reset  in  1  synchronous, active-high; clears all state.
pc_in  in  32  core PC for the current cycle.
ula_in  in  32  core ULA result for the current cycle.
dmem_in  in  32  core data-memory read value for the current cycle.
sample_en  in  1  qualifies the current cycle as a valid core cycle to record.
arm  in  1  one-cycle pulse; starts a capture session.
stop  in  1  one-cycle pulse; ends capture early.
trig_en  in  1  1 = wait for a PC match before capturing; 0 = capture immediately.
trig_pc  in  32  PC value that fires the trigger.
rd_ready  in  1  reader accepts the presented record.
rd_valid  out  1  a record is presented.
rd_pc  out  32  PC field of the head record.
rd_ula  out  32  ULA field of the head record.
rd_dmem  out  32  dmem field of the head record.
count  out  ADDR_W+1  records currently held (0..DEPTH).
state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.

Behaviour:
- Reset: state=IDLE; wr_ptr=rd_ptr=0; count=0; write counter=0; rd_valid=0.
- Reset: rd_pc, rd_ula and rd_dmem read as 0 while count=0. Buffer RAM contents are don't-care.
- Reset mid-capture or mid-drain: all of the above apply on the next edge, and every held record is discarded.
- IDLE: arm=1 and stop=0 -> ARMED, write counter cleared. stop has priority over arm in every state.
- ARMED, trig_en=0: -> CAPTURE on the next edge; nothing written in the ARMED cycle.
- ARMED, trig_en=1: sample_en=1 and pc_in==trig_pc -> that same cycle's record is written as record 0, write counter=1, -> CAPTURE.
- ARMED, stop=1: -> DONE with no records.
- CAPTURE: every cycle with sample_en=1 writes {pc_in, ula_in, dmem_in} at wr_ptr, then wr_ptr+1 (wraps mod DEPTH) and write counter+1.
- CAPTURE ends -> DONE on the edge where the write counter reaches DEPTH, or on stop=1. A write in the stop cycle is suppressed.
- Writes occur only in ARMED (trigger cycle) and CAPTURE. Total writes per session <= DEPTH, so overflow cannot occur.
- Read port is first-word-fall-through:
  - rd_valid = (count != 0); rd_* = record at rd_ptr, combinational from the buffer.
  - Transfer when rd_valid && rd_ready: rd_ptr+1 (wraps mod DEPTH).
  - rd_ready while empty is ignored.
  - Reads are allowed in every state, including concurrently with capture.
- count update: next = count + write - read. A simultaneous write and read leaves count unchanged.
- DONE: -> IDLE on the edge after count reaches 0. arm is ignored in DONE until then.
- trig_pc and trig_en are sampled only in ARMED.

Test Plan:
- reset; trig_en=0; arm; sample_en=1 with pc_in=0,4,8,... -> state 1 then 2; 16 records with PC 0x00..0x3C; state=3 with count=16; rd_ready=0 keeps rd_pc=0x00.
- From the previous state, rd_ready=1 for 16 cycles -> rd_pc 0x00..0x3C in order, ula and dmem matching; count reaches 0; state returns to 0 one cycle later.
- trig_en=1, trig_pc=0x20, PC stepping by 4 from 0 -> first record PC=0x20; records 0x20..0x5C; PCs below 0x20 are never stored.
- arm, capture 5 cycles, stop -> count=5; state=3; a sixth sample in the stop cycle is not stored.
- Capture with rd_ready=1 throughout -> rd_valid goes high 1 cycle after the first write; count stays <=1; all 16 records are read in order.
- reset asserted with count=7 in CAPTURE -> next cycle count=0, rd_valid=0, state=0. arm during DONE with count=3 -> ignored.
